fetch_cache: RTL and testbench

FETCH_CACHE -- requirements
Module: fetch_cache

---
 rtl/fetch_cache.sv | 263 ++++++++++++++++++++++++++
 tb/tb_fetch_cache.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_cache.sv
// Direct-mapped instruction fetch cache with an AXI4 read-burst refill engine.
// A line is refilled as a chain of BURST_LEN-beat INCR bursts, one outstanding at a time.
module fetch_cache #(
    parameter int C_M_AXI_ADDR_WIDTH      = 32,
    parameter int C_M_AXI_DATA_WIDTH      = 32,
    parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int NUM_LINES               = 4,
    parameter int LINE_WORDS              = 1024,
    parameter int BURST_LEN               = 32
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [31:0]                        I_ADDR,
    input  logic                               I_VALID,
    input  logic                               FLUSH,
    output logic                               MEM_WAIT,
    output logic [31:0]                        O_ADDR,
    output logic                               O_VALID,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      O_DATA,
    output logic                               ERR,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
    output logic [7:0]                         M_AXI_ARLEN,
    output logic [2:0]                         M_AXI_ARSIZE,
    output logic [1:0]                         M_AXI_ARBURST,
    output logic                               M_AXI_ARLOCK,
    output logic [3:0]                         M_AXI_ARCACHE,
    output logic [2:0]                         M_AXI_ARPROT,
    output logic [3:0]                         M_AXI_ARQOS,
    output logic                               M_AXI_ARUSER,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RLAST,
    input  logic                               M_AXI_RUSER,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY
);

    localparam int OFF_W     = $clog2(LINE_WORDS);
    localparam int IDX_W     = $clog2(NUM_LINES);
    localparam int IDX_WS    = (IDX_W > 0) ? IDX_W : 1;
    localparam int LINE_LSB  = OFF_W + 2;
    localparam int TAG_LSB   = LINE_LSB + IDX_W;
    localparam int TAG_W     = 32 - TAG_LSB;
    localparam int RAM_AW    = OFF_W + IDX_W;
    localparam int RAM_DEPTH = NUM_LINES * LINE_WORDS;
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES = C_M_AXI_ADDR_WIDTH'(BURST_LEN * 4);
    localparam logic [OFF_W-1:0]              LAST_WORD   = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t                          state_reg;
    state_t                          state_next;

    logic [OFF_W-1:0]                req_offset;
    logic [IDX_WS-1:0]               req_index;
    logic [TAG_W-1:0]                req_tag;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   line_base;

    logic                            valid_reg [NUM_LINES];
    logic [TAG_W-1:0]                tag_reg   [NUM_LINES];
    logic                            hit;

    logic [TAG_W-1:0]                fill_tag_reg;
    logic [IDX_WS-1:0]               fill_index_reg;
    logic [OFF_W-1:0]                beat_cnt_reg;
    logic                            fill_err_reg;
    logic                            flush_seen_reg;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_reg;
    logic                            arvalid_reg;
    logic                            err_reg;
    logic [31:0]                     o_addr_reg;
    logic                            o_valid_reg;
    logic [C_M_AXI_DATA_WIDTH-1:0]   o_data_reg;

    logic                            start_refill;
    logic                            ar_fire;
    logic                            beat;
    logic                            burst_done;
    logic                            line_done;
    logic                            beat_err;
    logic                            refill_err;
    logic                            commit;

    logic [C_M_AXI_DATA_WIDTH-1:0]   ram [RAM_DEPTH];
    logic [RAM_AW-1:0]               ram_waddr;
    logic [RAM_AW-1:0]               ram_raddr;

    logic                            unused_bits;

    // Address decomposition of the incoming fetch
    assign req_offset = I_ADDR[LINE_LSB-1:2];
    assign req_tag    = I_ADDR[31:TAG_LSB];
    assign line_base  = C_M_AXI_ADDR_WIDTH'({I_ADDR[31:LINE_LSB], {LINE_LSB{1'b0}}});

    generate
        if (IDX_W > 0) begin : g_index
            assign req_index = I_ADDR[TAG_LSB-1:LINE_LSB];
        end else begin : g_no_index
            assign req_index = '0;
        end
    endgenerate

    assign hit      = valid_reg[req_index] && (tag_reg[req_index] == req_tag);
    assign MEM_WAIT = I_VALID && !hit;

    // Refill control decode
    assign start_refill = (state_reg == IDLE) && I_VALID && !hit && !err_reg;
    assign ar_fire      = arvalid_reg && M_AXI_ARREADY;
    assign beat         = (state_reg == DATA) && M_AXI_RVALID;
    assign burst_done   = beat && M_AXI_RLAST;
    assign line_done    = burst_done && (beat_cnt_reg == LAST_WORD);
    assign beat_err     = (M_AXI_RRESP != 2'b00);
    assign refill_err   = fill_err_reg || (beat && beat_err);
    // A flush arriving on the final beat also vetoes the commit
    assign commit       = line_done && !refill_err && !flush_seen_reg && !FLUSH;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_refill) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (ar_fire) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (burst_done) begin
                    state_next = line_done ? IDLE : ADDR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fill_tag_reg   <= '0;
            fill_index_reg <= '0;
            beat_cnt_reg   <= '0;
            fill_err_reg   <= 1'b0;
            flush_seen_reg <= 1'b0;
            araddr_reg     <= '0;
            arvalid_reg    <= 1'b0;
        end else if (start_refill) begin
            fill_tag_reg   <= req_tag;
            fill_index_reg <= req_index;
            beat_cnt_reg   <= '0;
            fill_err_reg   <= 1'b0;
            flush_seen_reg <= 1'b0;
            araddr_reg     <= line_base;
            arvalid_reg    <= 1'b1;
        end else begin
            if (ar_fire) begin
                arvalid_reg <= 1'b0;
                araddr_reg  <= araddr_reg + BURST_BYTES;
            end
            if (beat) begin
                beat_cnt_reg <= beat_cnt_reg + OFF_W'(1);
                if (beat_err) begin
                    fill_err_reg <= 1'b1;
                end
            end
            if (burst_done && !line_done) begin
                arvalid_reg <= 1'b1;
            end
            if (FLUSH && (state_reg != IDLE)) begin
                flush_seen_reg <= 1'b1;
            end
        end
    end

    // Sticky bus error; only a flush (or reset) re-enables refills
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            err_reg <= 1'b0;
        end else if (line_done && refill_err) begin
            err_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
            // The line being refilled is invalid until its final beat commits
            always_ff @(posedge CLK) begin
                if (RST || FLUSH) begin
                    valid_reg[gi] <= 1'b0;
                end else if (start_refill && (req_index == IDX_WS'(gi))) begin
                    valid_reg[gi] <= 1'b0;
                end else if (commit && (fill_index_reg == IDX_WS'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end

            always_ff @(posedge CLK) begin
                if (commit && (fill_index_reg == IDX_WS'(gi))) begin
                    tag_reg[gi] <= fill_tag_reg;
                end
            end
        end
    endgenerate

    assign ram_waddr = RAM_AW'({fill_index_reg, beat_cnt_reg});
    assign ram_raddr = RAM_AW'({req_index, req_offset});

    always_ff @(posedge CLK) begin
        if (beat) begin
            ram[ram_waddr] <= M_AXI_RDATA;
        end
        o_data_reg <= ram[ram_raddr];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            o_addr_reg  <= '0;
            o_valid_reg <= 1'b0;
        end else begin
            o_addr_reg  <= I_ADDR;
            o_valid_reg <= I_VALID && hit;
        end
    end

    assign O_ADDR        = o_addr_reg;
    assign O_VALID       = o_valid_reg;
    assign O_DATA        = o_data_reg;
    assign ERR           = err_reg;

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = araddr_reg;
    assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARUSER  = 1'b0;
    assign M_AXI_ARVALID = arvalid_reg;
    assign M_AXI_RREADY  = 1'b1;

    assign unused_bits = ^{1'b0, I_ADDR[1:0], M_AXI_RID, M_AXI_RUSER};

endmodule

// File: tb/tb_fetch_cache.sv
// Randomized self-checking bench for fetch_cache: AXI slave model plus a line-level
// cache model (valid/tag per line) that predicts hits, refill traffic and data.
module tb_fetch_cache;

    localparam int NUM_LINES  = 4;
    localparam int LINE_WORDS = 1024;
    localparam int BURST_LEN  = 32;
    localparam int BURSTS     = LINE_WORDS / BURST_LEN;
    localparam int BUDGET     = 6000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic        i_valid;
    logic        flush;
    logic        mem_wait;
    logic [31:0] o_addr;
    logic        o_valid;
    logic [31:0] o_data;
    logic        err;
    logic [0:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic        aruser;
    logic        arvalid;
    logic        arready;
    logic [0:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        ruser;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int passes = 0;

    // Slave bookkeeping and line-level reference model
    int          ar_count   = 0;
    int          words_done = 0;
    int          hdr_bad    = 0;
    logic [31:0] ar_q[$];
    bit          inject_err = 1'b0;
    int          err_word   = 5;
    bit          mv[NUM_LINES];
    int          mt[NUM_LINES];

    always #5 clk = ~clk;

    fetch_cache dut (
        .CLK(clk), .RST(rst),
        .I_ADDR(i_addr), .I_VALID(i_valid), .FLUSH(flush),
        .MEM_WAIT(mem_wait), .O_ADDR(o_addr), .O_VALID(o_valid), .O_DATA(o_data), .ERR(err),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
        .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARUSER(aruser),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RUSER(ruser), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < NUM_LINES; i++) mv[i] = 1'b0;
    endfunction

    // AXI read slave: random AR accept delay and random idle gaps between beats
    initial begin : axi_slave
        logic [31:0] base;
        int          word_off;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        rdata = '0; rid = '0; ruser = 1'b0;
        forever begin
            @(negedge clk);
            if (arvalid === 1'b1 && rst === 1'b0) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                arready = 1'b1;
                base = araddr;
                if (arlen !== 8'd31 || arsize !== 3'b010 || arburst !== 2'b01 || arlock !== 1'b0 ||
                    arcache !== 4'b0011 || arprot !== 3'b000 || arqos !== 4'b0000 ||
                    aruser !== 1'b0 || arid !== 1'b0 || rready !== 1'b1)
                    hdr_bad++;
                @(negedge clk);
                arready = 1'b0;
                ar_q.push_back(base);
                ar_count++;
                for (int b = 0; b < BURST_LEN; b++) begin
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                    word_off = int'(((base >> 2) + 32'(b)) % LINE_WORDS);
                    rvalid = 1'b1;
                    rdata  = mem_word(base + 32'(4 * b));
                    rlast  = (b == BURST_LEN - 1);
                    rresp  = (inject_err && word_off == err_word) ? 2'b10 : 2'b00;
                    @(negedge clk);
                    words_done++;
                    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                end
            end
        end
    end

    // One fetch: model predicts hit/miss, refill traffic and returned word
    task automatic do_fetch(input logic [31:0] a, input string nm);
        int          idx, tg, ar0, w0, cyc;
        bit          exp_hit;
        logic [31:0] exp_data;
        @(negedge clk);
        idx      = int'((a >> 12) % NUM_LINES);
        tg       = int'(a >> 14);
        exp_hit  = mv[idx] && (mt[idx] == tg);
        exp_data = mem_word(a & 32'hFFFF_FFFC);
        ar0 = ar_count; w0 = words_done;
        i_addr = a; i_valid = 1'b1;
        #1;
        checks++;
        if (mem_wait !== !exp_hit) $display("FAIL %s mem_wait: got %b expected %b", nm, mem_wait, !exp_hit);
        else passes++;
        cyc = 0;
        while (mem_wait === 1'b1 && cyc < BUDGET) begin
            @(negedge clk); #1; cyc++;
        end
        checks++;
        if (mem_wait !== 1'b0) $display("FAIL %s refill_timeout: mem_wait got %b expected 0", nm, mem_wait);
        else passes++;
        if (!exp_hit) begin
            checks++;
            if (words_done - w0 != LINE_WORDS)
                $display("FAIL %s beats_before_valid: got %0d expected %0d", nm, words_done - w0, LINE_WORDS);
            else passes++;
        end
        checks++;
        if (ar_count - ar0 != (exp_hit ? 0 : BURSTS))
            $display("FAIL %s ar_bursts: got %0d expected %0d", nm, ar_count - ar0, exp_hit ? 0 : BURSTS);
        else passes++;
        mv[idx] = 1'b1; mt[idx] = tg;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_data !== exp_data || o_addr !== a)
            $display("FAIL %s output: got v=%b d=%h a=%h expected v=1 d=%h a=%h",
                     nm, o_valid, o_data, o_addr, exp_data, a);
        else passes++;
        i_valid = 1'b0;
        $display("fetch %s addr=%h hit=%0d data=%h", nm, a, exp_hit, o_data);
    endtask

    task automatic test_reset;
        rst = 1'b1; i_valid = 1'b0; flush = 1'b0; i_addr = 32'h0000_1234;
        repeat (3) @(negedge clk);
        checks++;
        if (arvalid !== 1'b0 || o_valid !== 1'b0 || err !== 1'b0 || araddr !== 32'h0 || o_addr !== 32'h0)
            $display("FAIL reset_state: got arvalid=%b o_valid=%b err=%b araddr=%h o_addr=%h expected all 0",
                     arvalid, o_valid, err, araddr, o_addr);
        else passes++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_addr !== 32'h0000_1234) $display("FAIL o_addr_follow: got %h expected 00001234", o_addr);
        else passes++;
        i_valid = 1'b1;
        #1;
        checks++;
        if (mem_wait !== 1'b1) $display("FAIL cold_mem_wait: got %b expected 1", mem_wait);
        else passes++;
        i_valid = 1'b0;
        model_flush();
        $display("reset done");
    endtask

    task automatic test_cold_miss;
        ar_q.delete();
        do_fetch(32'h0000_1004, "cold_miss");
        checks++;
        if (ar_q.size() != BURSTS) $display("FAIL cold_ar_count: got %0d expected %0d", ar_q.size(), BURSTS);
        else passes++;
        for (int k = 0; k < ar_q.size() && k < BURSTS; k++) begin
            checks++;
            if (ar_q[k] !== 32'h0000_1000 + 32'(k * 128))
                $display("FAIL cold_araddr[%0d]: got %h expected %h", k, ar_q[k], 32'h0000_1000 + 32'(k * 128));
            else passes++;
        end
    endtask

    task automatic test_back_to_back;
        int ar0;
        @(negedge clk);
        ar0 = ar_count;
        i_addr = 32'h0000_1000; i_valid = 1'b1;
        #1;
        checks++;
        if (mem_wait !== 1'b0) $display("FAIL b2b_hit0: mem_wait got %b expected 0", mem_wait);
        else passes++;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_data !== mem_word(32'h0000_1000))
            $display("FAIL b2b_data0: got v=%b d=%h expected v=1 d=%h", o_valid, o_data, mem_word(32'h0000_1000));
        else passes++;
        i_addr = 32'h0000_1008;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_data !== mem_word(32'h0000_1008) || o_addr !== 32'h0000_1008)
            $display("FAIL b2b_data1: got v=%b d=%h a=%h expected v=1 d=%h a=00001008",
                     o_valid, o_data, o_addr, mem_word(32'h0000_1008));
        else passes++;
        i_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || ar_count != ar0)
            $display("FAIL b2b_idle: got v=%b ar=%0d expected v=0 ar=0", o_valid, ar_count - ar0);
        else passes++;
        $display("back_to_back 0x1000,0x1008 done");
    endtask

    task automatic test_conflict;
        do_fetch(32'h0000_5000, "conflict_evict");
        do_fetch(32'h0000_1000, "conflict_refetch");
    endtask

    task automatic test_multi_line;
        int ar0;
        do_fetch(32'h0000_2000, "multi_fill");
        ar0 = ar_count;
        do_fetch(32'h0000_1000, "multi_a0");
        do_fetch(32'h0000_2004, "multi_b0");
        do_fetch(32'h0000_1FFC, "multi_a1");
        do_fetch(32'h0000_2FFC, "multi_b1");
        checks++;
        if (ar_count != ar0) $display("FAIL multi_ar: got %0d expected 0", ar_count - ar0);
        else passes++;
    endtask

    task automatic test_error;
        int ar0, w0, cyc;
        @(negedge clk);
        inject_err = 1'b1; err_word = 5;
        ar0 = ar_count; w0 = words_done;
        i_addr = 32'h0000_3010; i_valid = 1'b1;
        cyc = 0;
        while (err !== 1'b1 && cyc < BUDGET) begin
            @(negedge clk); #1; cyc++;
        end
        checks++;
        if (err !== 1'b1 || words_done - w0 != LINE_WORDS)
            $display("FAIL err_set: got err=%b beats=%0d expected err=1 beats=%0d", err, words_done - w0, LINE_WORDS);
        else passes++;
        inject_err = 1'b0;
        repeat (50) @(negedge clk);
        #1;
        checks++;
        if (mem_wait !== 1'b1 || o_valid !== 1'b0 || err !== 1'b1 || ar_count - ar0 != BURSTS)
            $display("FAIL err_hold: got wait=%b v=%b err=%b ar=%0d expected 1 0 1 %0d",
                     mem_wait, o_valid, err, ar_count - ar0, BURSTS);
        else passes++;
        i_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) $display("FAIL err_clear: got %b expected 0", err);
        else passes++;
        model_flush();
        $display("error refill: err set and cleared by flush");
        do_fetch(32'h0000_3010, "err_retry");
    endtask

    task automatic test_flush_mid;
        int ar0, w0, cyc;
        @(negedge clk);
        ar0 = ar_count; w0 = words_done;
        i_addr = 32'h0000_6008; i_valid = 1'b1;
        cyc = 0;
        while (words_done - w0 < 100 && cyc < BUDGET) begin
            @(negedge clk); #1; cyc++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_flush();
        cyc = 0;
        while (words_done - w0 < LINE_WORDS && cyc < BUDGET) begin
            @(negedge clk); #1; cyc++;
        end
        checks++;
        if (mem_wait !== 1'b1 || ar_count - ar0 != BURSTS || words_done - w0 != LINE_WORDS)
            $display("FAIL flush_no_commit: got wait=%b ar=%0d beats=%0d expected 1 %0d %0d",
                     mem_wait, ar_count - ar0, words_done - w0, BURSTS, LINE_WORDS);
        else passes++;
        cyc = 0;
        while (mem_wait === 1'b1 && cyc < BUDGET) begin
            @(negedge clk); #1; cyc++;
        end
        checks++;
        if (mem_wait !== 1'b0 || ar_count - ar0 != 2 * BURSTS || words_done - w0 != 2 * LINE_WORDS)
            $display("FAIL flush_refill: got wait=%b ar=%0d beats=%0d expected 0 %0d %0d",
                     mem_wait, ar_count - ar0, words_done - w0, 2 * BURSTS, 2 * LINE_WORDS);
        else passes++;
        mv[2] = 1'b1; mt[2] = 1;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_data !== mem_word(32'h0000_6008))
            $display("FAIL flush_data: got v=%b d=%h expected v=1 d=%h", o_valid, o_data, mem_word(32'h0000_6008));
        else passes++;
        i_valid = 1'b0;
        $display("flush mid-refill: line discarded then refetched");
    endtask

    task automatic test_random;
        logic [31:0] a;
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                model_flush();
                $display("random flush");
            end
            a = (32'($urandom_range(0, 1)) << 14) | (32'($urandom_range(0, 3)) << 12) |
                (32'($urandom_range(0, LINE_WORDS - 1)) << 2) | 32'($urandom_range(0, 3));
            do_fetch(a, "random");
        end
    endtask

    task automatic test_ar_fields;
        checks++;
        if (hdr_bad != 0) $display("FAIL ar_fields: got %0d bad AR headers expected 0", hdr_bad);
        else passes++;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst = 1'b1; i_valid = 1'b0; flush = 1'b0; i_addr = '0;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_multi_line();
        test_error();
        test_flush_mid();
        test_random();
        test_ar_fields();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
